// File: rtl/coprocessor0_params.sv
// Shared CP0 definitions: sequencer state encoding, MIPS ExcCode values and the
// commit record handed from the exception sequencer to coprocessor 0.
package coprocessor0_params;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        FLUSH,
        REDIRECT
    } SequencerState;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic        valid;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        in_delay_slot;
    } CP0CommitData;

endpackage

// File: rtl/irq_synchronizer.sv
// Two-flop synchronizer for the raw hardware interrupt lines; used by the
// exception sequencer only when CP0_IRQ_SYNC_EN is defined.
module irq_synchronizer #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            stage1 <= async_in;
            stage2 <= stage1;
        end
    end

    assign sync_out = stage2;

endmodule

// File: rtl/cp0_exception_sequencer.sv
// Sequences interrupt/exception/ERET events at WB: one CP0 commit, a pipeline flush,
// then a PC redirect to IF. Define CP0_IRQ_SYNC_EN to add a 2-flop irq synchronizer.
module cp0_exception_sequencer
    import coprocessor0_params::*;
#(
    parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_exception_valid,
    input  logic [4:0]  wb_exception_code,
    input  logic [31:0] wb_pc,
    input  logic        wb_in_delay_slot,
    input  logic        wb_eret,
    input  logic [5:0]  hw_interrupt,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    input  logic [1:0]  cause_ip_sw,
    input  logic [31:0] epc,
    output logic [5:0]  cause_ip_hw,
    output logic        wb_cancel,
    output logic        wb_stall,
    output logic        cp0_commit_valid,
    output logic        cp0_commit_eret,
    output logic [4:0]  cp0_commit_code,
    output logic [31:0] cp0_commit_pc,
    output logic        cp0_commit_bd,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    SequencerState    state;
    SequencerState    state_next;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] flush_cnt_next;
    CP0CommitData     latched;
    CP0CommitData     latched_next;
    logic [31:0]      target;
    logic [31:0]      target_next;

    logic [7:0]       pend;
    logic             irq_take;
    logic             event_take;

`ifdef CP0_IRQ_SYNC_EN
    irq_synchronizer #(
        .WIDTH(6)
    ) u_irq_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (hw_interrupt),
        .sync_out (cause_ip_hw)
    );
`else
    always_ff @(posedge clock) begin
        if (!reset) begin
            cause_ip_hw <= '0;
        end else begin
            cause_ip_hw <= hw_interrupt;
        end
    end
`endif

    // Interrupts are judged on the sampled lines, so the decision is stable for the whole cycle.
    always_comb begin
        pend       = {cause_ip_hw, cause_ip_sw} & status_im;
        irq_take   = status_ie & ~status_exl & (|pend);
        event_take = wb_valid & (irq_take | wb_exception_valid | wb_eret);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            flush_cnt <= '0;
            latched   <= '0;
            target    <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            latched   <= latched_next;
            target    <= target_next;
        end
    end

    always_comb begin
        state_next       = state;
        flush_cnt_next   = flush_cnt;
        latched_next     = latched;
        target_next      = target;
        wb_cancel        = 1'b0;
        cp0_commit_valid = 1'b0;
        cp0_commit_eret  = 1'b0;
        cp0_commit_code  = 5'h00;
        cp0_commit_pc    = 32'h0;
        cp0_commit_bd    = 1'b0;
        pipe_flush       = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;

        case (state)
            IDLE: begin
                // ERET alone must still write back; only faulting/interrupted instructions are cancelled.
                wb_cancel = wb_valid & (irq_take | wb_exception_valid);
                if (event_take) begin
                    latched_next.valid         = 1'b1;
                    latched_next.pc            = wb_pc;
                    latched_next.in_delay_slot = wb_in_delay_slot;
                    if (irq_take) begin
                        latched_next.eret = 1'b0;
                        latched_next.code = EXC_INT;
                        target_next       = EXCEPTION_VECTOR;
                    end else if (wb_exception_valid) begin
                        latched_next.eret = 1'b0;
                        latched_next.code = wb_exception_code;
                        target_next       = EXCEPTION_VECTOR;
                    end else begin
                        latched_next.eret = 1'b1;
                        latched_next.code = EXC_INT;
                        target_next       = epc;
                    end
                    state_next = COMMIT;
                end
            end

            COMMIT: begin
                cp0_commit_valid = latched.valid;
                cp0_commit_eret  = latched.eret;
                cp0_commit_code  = latched.code;
                cp0_commit_pc    = latched.pc;
                cp0_commit_bd    = latched.in_delay_slot;
                flush_cnt_next   = CNT_W'(FLUSH_CYCLES);
                state_next       = FLUSH;
            end

            FLUSH: begin
                pipe_flush     = 1'b1;
                flush_cnt_next = flush_cnt - CNT_W'(1);
                if (flush_cnt == CNT_W'(1)) begin
                    state_next = REDIRECT;
                end
            end

            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target;
                if (redirect_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wb_stall = (state != IDLE);

endmodule
